// File: rtl/aes_io_pkg.sv
// aes_io_pkg: shared types and constants for the AES host I/O block.
//   state_e        host-side handshake FSM states
//   KEY_BASE/MSG_BASE  host word addresses of the key and ciphertext banks
//   WORDS/WORD_W   bank geometry (4 x 32-bit words = 128 bits)
//   word_lsb()     bit offset of a word index; word 0 is the most significant
package aes_io_pkg;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    CAPTURE,
    RECOVER,
    DONE
  } state_e;

  localparam logic [2:0]  KEY_BASE = 3'd0;
  localparam logic [2:0]  MSG_BASE = 3'd4;
  localparam int unsigned WORDS    = 4;
  localparam int unsigned WORD_W   = 32;

  // Big-endian word order: index 0 maps to bits [127:96].
  function automatic int unsigned word_lsb(input int unsigned idx);
    return (WORDS - 1 - idx) * WORD_W;
  endfunction

endpackage

// File: rtl/aes_word_bank.sv
// aes_word_bank: 4 x 32-bit register bank with per-word written mask.
//   clk, reset_n   clock, asynchronous active-low reset
//   wr_en, wr_idx, wr_data   single-word write; sets mask[wr_idx]
//   clear_mask     clears the whole mask (data is kept)
//   words          128-bit concatenation, word 0 in the top bits
//   mask           one bit per word written since the last clear
module aes_word_bank
  import aes_io_pkg::*;
(
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    wr_en,
  input  logic [1:0]              wr_idx,
  input  logic [WORD_W-1:0]       wr_data,
  input  logic                    clear_mask,
  output logic [WORDS*WORD_W-1:0] words,
  output logic [WORDS-1:0]        mask
);

  logic [WORDS*WORD_W-1:0] words_q, words_d;
  logic [WORDS-1:0]        mask_q, mask_d;

  always_comb begin
    words_d = words_q;
    mask_d  = mask_q;
    for (int unsigned i = 0; i < WORDS; i++) begin
      if (wr_en && (wr_idx == 2'(i))) begin
        words_d[word_lsb(i) +: WORD_W] = wr_data;
        mask_d[i]                      = 1'b1;
      end
    end
    // A clear coinciding with a write wins: that word was consumed by the
    // request that caused the clear.
    if (clear_mask) mask_d = '0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      words_q <= '0;
      mask_q  <= '0;
    end else begin
      words_q <= words_d;
      mask_q  <= mask_d;
    end
  end

  assign words = words_q;
  assign mask  = mask_q;

endmodule

// File: rtl/aes_host_io.sv
// aes_host_io: host side of the AES controller handshake.
//   clk, reset_n           clock, asynchronous active-low reset
//   wr_en/wr_addr/wr_data  host word writes: 0-3 key, 4-7 ciphertext
//   rd_en/rd_addr          result word read; rd_data/rd_valid one cycle later
//   start                  request pulse; start_err pulses when rejected
//   busy, done             in-flight flag, sticky result-valid flag
//   msg_en, key, io_ready  request towards the controller
//   msg_de, aes_ready      response from the controller
//   core_rst_n             soft reset to the controller after each result
// Optional: define AES_TIMEOUT_EN to add the TIMEOUT_CYCLES parameter, a REQ
// watchdog and the sticky timeout_err output.
module aes_host_io
  import aes_io_pkg::*;
#(
  parameter int unsigned RST_CYCLES = 2
`ifdef AES_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT_CYCLES = 4096
`endif
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         wr_en,
  input  logic [2:0]   wr_addr,
  input  logic [31:0]  wr_data,
  input  logic         rd_en,
  input  logic [1:0]   rd_addr,
  output logic [31:0]  rd_data,
  output logic         rd_valid,
  input  logic         start,
  output logic         busy,
  output logic         done,
  output logic         start_err,
  output logic [127:0] msg_en,
  output logic [127:0] key,
  output logic         io_ready,
  input  logic [127:0] msg_de,
  input  logic         aes_ready,
  output logic         core_rst_n
`ifdef AES_TIMEOUT_EN
  ,
  output logic         timeout_err
`endif
);

  localparam int unsigned RCW = $clog2(RST_CYCLES + 1);

  state_e         state_q, state_d;
  logic [RCW-1:0] rcnt_q, rcnt_d;
  logic [127:0]   result_q, result_d;
  logic [31:0]    rd_data_q, rd_data_d;
  logic           rd_valid_q, rd_valid_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic           start_err_q, start_err_d;
  logic           io_ready_q, io_ready_d;
  logic           core_rst_q, core_rst_d;

  logic           host_open, wr_ok, start_ok;
  logic           key_wr, msg_wr;
  logic [1:0]     key_idx, msg_idx;
  logic [3:0]     key_mask, msg_mask;

`ifdef AES_TIMEOUT_EN
  localparam int unsigned TCW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TCW-1:0] tcnt_q, tcnt_d;
  logic           timeout_q, timeout_d;
`endif

  assign host_open = (state_q == IDLE) || (state_q == DONE);
  assign wr_ok     = wr_en && host_open;
  // Masks are sampled before any same-cycle write lands.
  assign start_ok  = start && host_open && (&key_mask) && (&msg_mask);

  assign key_wr  = wr_ok && (wr_addr < MSG_BASE);
  assign msg_wr  = wr_ok && (wr_addr >= MSG_BASE);
  assign key_idx = 2'(wr_addr - KEY_BASE);
  assign msg_idx = 2'(wr_addr - MSG_BASE);

  aes_word_bank u_key_bank (
    .clk        (clk),
    .reset_n    (reset_n),
    .wr_en      (key_wr),
    .wr_idx     (key_idx),
    .wr_data    (wr_data),
    .clear_mask (1'b0),
    .words      (key),
    .mask       (key_mask)
  );

  aes_word_bank u_msg_bank (
    .clk        (clk),
    .reset_n    (reset_n),
    .wr_en      (msg_wr),
    .wr_idx     (msg_idx),
    .wr_data    (wr_data),
    .clear_mask (start_ok),
    .words      (msg_en),
    .mask       (msg_mask)
  );

  always_comb begin
    state_d     = state_q;
    rcnt_d      = rcnt_q;
    result_d    = result_q;
    start_err_d = start && host_open && !start_ok;
`ifdef AES_TIMEOUT_EN
    timeout_d   = timeout_q;
`endif

    case (state_q)
      IDLE, DONE: begin
        if (start_ok) begin
          state_d = REQ;
`ifdef AES_TIMEOUT_EN
          timeout_d = 1'b0;
`endif
        end
      end
      REQ: begin
        // Capture on the REQ->CAPTURE edge so the result is valid during CAPTURE.
        if (aes_ready) begin
          state_d  = CAPTURE;
          result_d = msg_de;
        end
`ifdef AES_TIMEOUT_EN
        else if (tcnt_q == TCW'(TIMEOUT_CYCLES - 1)) begin
          state_d   = RECOVER;
          rcnt_d    = RCW'(RST_CYCLES - 1);
          timeout_d = 1'b1;
        end
`endif
      end
      CAPTURE: begin
        state_d = RECOVER;
        rcnt_d  = RCW'(RST_CYCLES - 1);
      end
      RECOVER: begin
        if (rcnt_q == '0) begin
`ifdef AES_TIMEOUT_EN
          state_d = timeout_q ? IDLE : DONE;
`else
          state_d = DONE;
`endif
        end else begin
          rcnt_d = rcnt_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

`ifdef AES_TIMEOUT_EN
    tcnt_d = ((state_q == REQ) && (state_d == REQ)) ? tcnt_q + 1'b1 : '0;
`endif

    // Outputs are registered from the next state so they align with it.
    io_ready_d = (state_d == REQ);
    busy_d     = (state_d == REQ) || (state_d == CAPTURE) || (state_d == RECOVER);
    done_d     = (state_d == DONE);
    core_rst_d = (state_d != RECOVER);

    rd_valid_d = rd_en;
    rd_data_d  = rd_data_q;
    if (rd_en) begin
      for (int unsigned i = 0; i < WORDS; i++) begin
        if (rd_addr == 2'(i)) rd_data_d = result_q[word_lsb(i) +: WORD_W];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      rcnt_q      <= '0;
      result_q    <= '0;
      rd_data_q   <= '0;
      rd_valid_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      start_err_q <= 1'b0;
      io_ready_q  <= 1'b0;
      core_rst_q  <= 1'b0;
`ifdef AES_TIMEOUT_EN
      tcnt_q      <= '0;
      timeout_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      rcnt_q      <= rcnt_d;
      result_q    <= result_d;
      rd_data_q   <= rd_data_d;
      rd_valid_q  <= rd_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      start_err_q <= start_err_d;
      io_ready_q  <= io_ready_d;
      core_rst_q  <= core_rst_d;
`ifdef AES_TIMEOUT_EN
      tcnt_q      <= tcnt_d;
      timeout_q   <= timeout_d;
`endif
    end
  end

  assign rd_data    = rd_data_q;
  assign rd_valid   = rd_valid_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign start_err  = start_err_q;
  assign io_ready   = io_ready_q;
  assign core_rst_n = core_rst_q;
`ifdef AES_TIMEOUT_EN
  assign timeout_err = timeout_q;
`endif

endmodule

// File: tb/tb_aes_host_io.sv
// tb_aes_host_io: table-driven bench for aes_host_io with a read scoreboard
// and a stub AES controller that answers a fixed delay after io_ready.
module tb_aes_host_io;

  localparam int RST = 2;

  localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] FIPS_MSG = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] FIPS_RES = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] MSG2     = 128'h1111111122222222333333334444_4444;
  localparam logic [127:0] RES2     = 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;

  logic         clk, reset_n;
  logic         wr_en, rd_en, start;
  logic [2:0]   wr_addr;
  logic [31:0]  wr_data, rd_data;
  logic [1:0]   rd_addr;
  logic         rd_valid, busy, done, start_err, io_ready, aes_ready, core_rst_n;
  logic [127:0] msg_en, key, msg_de;
`ifdef AES_TIMEOUT_EN
  logic         timeout_err;
`endif

  aes_host_io #(
    .RST_CYCLES     (RST)
`ifdef AES_TIMEOUT_EN
    ,
    .TIMEOUT_CYCLES (16)
`endif
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .rd_en      (rd_en),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .rd_valid   (rd_valid),
    .start      (start),
    .busy       (busy),
    .done       (done),
    .start_err  (start_err),
    .msg_en     (msg_en),
    .key        (key),
    .io_ready   (io_ready),
    .msg_de     (msg_de),
    .aes_ready  (aes_ready),
    .core_rst_n (core_rst_n)
`ifdef AES_TIMEOUT_EN
    ,
    .timeout_err(timeout_err)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Stub controller: raises aes_ready stub_delay cycles after io_ready.
  logic         stub_en;
  int           stub_delay;
  int           stub_cnt;
  logic [127:0] stub_res;
  assign msg_de = stub_res;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stub_cnt  <= 0;
      aes_ready <= 1'b0;
    end else if (io_ready && !aes_ready && stub_en) begin
      stub_cnt <= stub_cnt + 1;
      if (stub_cnt + 1 == stub_delay) aes_ready <= 1'b1;
    end else if (!io_ready) begin
      stub_cnt  <= 0;
      aes_ready <= 1'b0;
    end
  end

  // Read scoreboard.
  logic [31:0] exp_q[$];
  always @(negedge clk) begin
    if (rd_valid) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL rd_unexpected: got %h expected no read", rd_data);
      end else begin
        check("rd_data", {96'h0, rd_data}, {96'h0, exp_q.pop_front()});
      end
    end
  end

  typedef enum {OP_WR, OP_START, OP_RD} op_e;
  typedef struct {
    op_e         op;
    logic [2:0]  addr;
    logic [31:0] data;
    logic        exp_err;
    logic        exp_busy;
  } vec_t;

  vec_t tbl[$];
  int   vi = 0;

  function automatic logic [31:0] wd(input logic [127:0] v, input int i);
    return v[(3 - i) * 32 +: 32];
  endfunction

  function automatic void add(input op_e op, input int addr, input logic [31:0] data,
                              input logic err, input logic bsy);
    vec_t v;
    v.op = op; v.addr = 3'(addr); v.data = data; v.exp_err = err; v.exp_busy = bsy;
    tbl.push_back(v);
  endfunction

  function automatic void add_words(input int base, input logic [127:0] v);
    for (int i = 0; i < 4; i++) add(OP_WR, base + i, wd(v, i), 1'b0, 1'b0);
  endfunction

  function automatic void add_reads(input logic [127:0] v);
    for (int i = 0; i < 4; i++) add(OP_RD, i, wd(v, i), 1'b0, 1'b0);
  endfunction

  task automatic apply_vec(input vec_t v);
    case (v.op)
      OP_WR:    begin wr_en = 1'b1; wr_addr = v.addr; wr_data = v.data; end
      OP_START: start = 1'b1;
      OP_RD:    begin rd_en = 1'b1; rd_addr = v.addr[1:0]; exp_q.push_back(v.data); end
      default:  ;
    endcase
    @(posedge clk); #1;
    wr_en = 1'b0; start = 1'b0; rd_en = 1'b0;
    if (v.op == OP_START) begin
      check("start_err", {127'h0, start_err}, {127'h0, v.exp_err});
      check("busy_after_start", {127'h0, busy}, {127'h0, v.exp_busy});
      check("io_ready_after_start", {127'h0, io_ready}, {127'h0, v.exp_busy});
    end
  endtask

  task automatic run_vecs(input int n);
    for (int k = 0; k < n; k++) begin
      apply_vec(tbl[vi]);
      vi++;
    end
  endtask

  // Called one time unit after the edge that accepted start.
  task automatic run_request(input logic [127:0] exp_msg);
    int io_hi = 0;
    int rst_lo = 0;
    int done_at = -1;
    for (int s = 0; s < 200 && done_at < 0; s++) begin
      if (io_ready) io_hi++;
      if (!core_rst_n) rst_lo++;
      if (done) done_at = s;
      if (s == 10) begin
        check("key_stable_req", key, FIPS_KEY);
        check("msg_stable_req", msg_en, exp_msg);
      end
      if (done_at < 0) begin
        wr_en = (s == 2); wr_addr = 3'd2; wr_data = 32'hdeadbeef;
        start = (s == 4);
        @(posedge clk); #1;
        wr_en = 1'b0; start = 1'b0;
        if (s == 4) check("start_while_busy", {127'h0, start_err}, 128'h0);
      end
    end
    check("io_ready_cycles", 128'(io_hi), 128'(stub_delay + 1));
    check("core_rst_low_cycles", 128'(rst_lo), 128'(RST));
    check("done_latency", 128'(done_at), 128'(stub_delay + RST + 2));
  endtask

  initial begin
    reset_n = 1'b0; wr_en = 1'b0; rd_en = 1'b0; start = 1'b0;
    wr_addr = '0; wr_data = '0; rd_addr = '0;
    stub_en = 1'b0; stub_delay = 20; stub_res = FIPS_RES;

    // Phase 1: first request, including a rejected start.
    add(OP_RD, 0, 32'h0, 1'b0, 1'b0);
    add_words(0, FIPS_KEY);
    for (int i = 0; i < 3; i++) add(OP_WR, 4 + i, wd(FIPS_MSG, i), 1'b0, 1'b0);
    add(OP_START, 0, 32'h0, 1'b1, 1'b0);
    add(OP_WR, 7, wd(FIPS_MSG, 3), 1'b0, 1'b0);
    add(OP_START, 0, 32'h0, 1'b0, 1'b1);
    // Phase 2: readback, start without fresh msg, key reuse.
    add_reads(FIPS_RES);
    add(OP_START, 0, 32'h0, 1'b1, 1'b0);
    add_words(4, MSG2);
    add(OP_START, 0, 32'h0, 1'b0, 1'b1);
    // Phase 3: second result.
    add_reads(RES2);
`ifdef AES_TIMEOUT_EN
    add_words(4, FIPS_MSG);
    add(OP_START, 0, 32'h0, 1'b0, 1'b1);
    add(OP_RD, 0, wd(RES2, 0), 1'b0, 1'b0);
    add(OP_START, 0, 32'h0, 1'b1, 1'b0);
    add_words(4, FIPS_MSG);
    add(OP_START, 0, 32'h0, 1'b0, 1'b1);
`endif
    // Phase 4: request to be interrupted by reset.
    add_words(4, FIPS_MSG);
    add(OP_START, 0, 32'h0, 1'b0, 1'b1);
    // Phase 5: after reset.
    add(OP_START, 0, 32'h0, 1'b1, 1'b0);
    add(OP_RD, 0, 32'h0, 1'b0, 1'b0);

    #3;
    check("rst_core_rst_n", {127'h0, core_rst_n}, 128'h0);
    check("rst_io_ready", {127'h0, io_ready}, 128'h0);
    check("rst_busy", {127'h0, busy}, 128'h0);
    check("rst_done", {127'h0, done}, 128'h0);
    check("rst_start_err", {127'h0, start_err}, 128'h0);
    check("rst_rd", {95'h0, rd_valid, rd_data}, 128'h0);
    check("rst_key", key, 128'h0);
    check("rst_msg", msg_en, 128'h0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
    check("core_rst_n_idle", {127'h0, core_rst_n}, 128'h1);
    stub_en = 1'b1;

    run_vecs(11);
    run_request(FIPS_MSG);
    check("key_after_busy_write", key, FIPS_KEY);
    check("msg_after_req1", msg_en, FIPS_MSG);
    check("done_req1", {127'h0, done}, 128'h1);
    check("core_rst_n_done", {127'h0, core_rst_n}, 128'h1);

    stub_res = RES2;
    run_vecs(5);
    check("done_after_rejected", {127'h0, done}, 128'h1);
    run_vecs(5);
    run_request(MSG2);
    check("key_reused", key, FIPS_KEY);
    check("msg_req2", msg_en, MSG2);
    run_vecs(4);

`ifdef AES_TIMEOUT_EN
    stub_en = 1'b0;
    run_vecs(5);
    begin
      int io_hi = 0;
      int rst_lo = 0;
      int idle_at = -1;
      for (int s = 0; s < 100 && idle_at < 0; s++) begin
        if (io_ready) io_hi++;
        if (!core_rst_n) rst_lo++;
        if (!busy) idle_at = s;
        else begin @(posedge clk); #1; end
      end
      check("to_io_ready_cycles", 128'(io_hi), 128'd16);
      check("to_core_rst_low", 128'(rst_lo), 128'(RST));
      check("to_idle_at", 128'(idle_at), 128'(16 + RST));
      check("to_done", {127'h0, done}, 128'h0);
      check("to_timeout_err", {127'h0, timeout_err}, 128'h1);
    end
    run_vecs(7);
    check("to_err_cleared", {127'h0, timeout_err}, 128'h0);
    begin
      int idle_at = -1;
      for (int s = 0; s < 100 && idle_at < 0; s++) begin
        if (!busy) idle_at = s;
        else begin @(posedge clk); #1; end
      end
      check("to_second_idle", 128'(idle_at), 128'(16 + RST));
    end
`endif

    stub_en = 1'b0;
    run_vecs(5);
    repeat (3) begin @(posedge clk); #1; end
    check("pre_rst_io_ready", {127'h0, io_ready}, 128'h1);
    #3;
    reset_n = 1'b0;
    #1;
    check("mid_rst_io_ready", {127'h0, io_ready}, 128'h0);
    check("mid_rst_core_rst_n", {127'h0, core_rst_n}, 128'h0);
    check("mid_rst_done", {127'h0, done}, 128'h0);
    check("mid_rst_busy", {127'h0, busy}, 128'h0);
    check("mid_rst_key", key, 128'h0);
    #2;
    reset_n = 1'b1;
    @(posedge clk); #1;
    run_vecs(2);

    repeat (3) begin @(posedge clk); #1; end
    check("scoreboard_empty", 128'(exp_q.size()), 128'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/aes_host_io.md
Name: aes_host_io

Overview:
- Host-side end of the AES controller handshake (msg_en/key/io_ready in one direction, msg_de/aes_ready in the other).
- The host writes the 128-bit key and 128-bit ciphertext as 32-bit words, then issues start.
- The block drives io_ready to the AES controller until aes_ready is seen, latches msg_de into a result bank for 32-bit readback, then soft-resets the controller so the next request can run.
- Sits between the bus/NIOS peripheral and the AES controller.

Parameters:
- RST_CYCLES, 2, number of cycles core_rst_n is held low after each result capture (must be >= 1).
- TIMEOUT_CYCLES, 4096, maximum cycles in REQ before abort (used only with AES_TIMEOUT_EN).

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous, active-low reset
- wr_en  in  1  host word write strobe
- wr_addr  in  3  0-3 key words, 4-7 ciphertext words
- wr_data  in  32  host write data
- rd_en  in  1  host read strobe
- rd_addr  in  2  result word select
- rd_data  out  32  result word, registered
- rd_valid  out  1  high one cycle after rd_en
- start  in  1  request decryption (single-cycle pulse)
- busy  out  1  high in REQ, CAPTURE, RECOVER
- done  out  1  sticky result-valid flag
- start_err  out  1  one-cycle pulse: start rejected
- msg_en  out  128  ciphertext to controller
- key  out  128  key to controller
- io_ready  out  1  request to controller
- msg_de  in  128  plaintext from controller
- aes_ready  in  1  controller result valid
- core_rst_n  out  1  active-low soft reset to controller

Behaviour:
- Reset is asynchronous, active-low on reset_n; clock is clk.
- Reset values: all banks 0, masks 0, state IDLE, io_ready 0, busy 0, done 0, start_err 0, rd_data 0, rd_valid 0. core_rst_n = 0 combinationally while reset_n = 0.
- Word order is big-endian: word 0 = bits [127:96], word 3 = bits [31:0]. Key uses addrs 0-3 and msg_en uses 4-7. rd_addr 0 = result [127:96].
- key_mask[3:0] and msg_mask[3:0] set the bit for each written word. Writes are accepted only in IDLE and DONE; all other writes are silently dropped.
- start is accepted in IDLE or DONE only if key_mask = 4'hF and msg_mask = 4'hF, using the mask value before any same-cycle write.
  - On acceptance: msg_mask is cleared (key is retained for reuse), done is cleared, next state is REQ.
  - Otherwise: start_err pulses for 1 cycle and the state is unchanged.
  - start while busy: ignored, no start_err.
- FSM:
  - IDLE: wait for start.
  - REQ: io_ready = 1; on aes_ready = 1 go to CAPTURE.
  - CAPTURE (1 cycle): result bank <= msg_de; io_ready = 0; go to RECOVER.
  - RECOVER: core_rst_n = 0 for exactly RST_CYCLES cycles (down-counter), then go to DONE.
  - DONE: done = 1; accepts writes and start, as in IDLE.
- core_rst_n = 1 in every state except RECOVER.
- Latency: aes_ready high in cycle N -> result bank valid in N+1 -> done = 1 in N+1+RST_CYCLES+1.
- aes_ready seen high on the same cycle REQ is entered: capture proceeds normally.
- msg_en and key are driven continuously from the banks and are stable throughout REQ (writes are blocked).
- Reads are allowed in any state:
  - rd_data = result[rd_addr] registered one cycle after rd_en; rd_valid pulses in the same cycle.
  - Reading before the first result returns 0.
- Reset mid-operation: everything returns to reset values, core_rst_n is low, masks are cleared, and the host must reload.

Optional Feature:
- Macro: AES_TIMEOUT_EN.
- With it defined:
  - A cycle counter runs in REQ.
  - If the counter reaches TIMEOUT_CYCLES without aes_ready, the block skips CAPTURE and goes to RECOVER, leaves the result bank unchanged, and sets the sticky output timeout_err (extra 1-bit port).
  - After RECOVER it goes to IDLE instead of DONE, and done stays 0.
  - timeout_err is cleared on the next accepted start.
- Without it: REQ waits indefinitely, and neither the port nor the counter exists.

Decomposition:
- Package aes_io_pkg holds:
  - the state enum {IDLE, REQ, CAPTURE, RECOVER, DONE};
  - address constants KEY_BASE = 0 and MSG_BASE = 4;
  - WORDS = 4 and WORD_W = 32.
- Sub-module aes_word_bank: a 4x32 register bank with a write-mask, a clear_mask input and a 128-bit concatenated output. It is instantiated for key and msg; the result bank is a plain 128-bit register.

Test Plan:
- FIPS-197 vector: key words 00010203, 04050607, 08090a0b, 0c0d0e0f; msg 69c4e0d8, 6a7b0430, d8cdb780, 70b4c55a; start. A stub controller returns 00112233445566778899aabbccddeeff after 20 cycles. Required response: io_ready high until aes_ready, core_rst_n low exactly 2 cycles, done = 1, reads of addrs 0-3 return 00112233, 44556677, 8899aabb, ccddeeff.
- Start with msg word 7 unwritten -> start_err pulse, state stays IDLE, io_ready stays 0. Then write word 7 and start -> accepted.
- Second request reusing the key (only msg words rewritten) -> accepted. Start without rewriting msg -> start_err.
- Writes to addr 2 while busy -> key output unchanged, and the result matches the original key.
- Assert reset_n in REQ -> io_ready 0, core_rst_n 0, done 0, masks 0 immediately (asynchronous).
- With AES_TIMEOUT_EN, TIMEOUT_CYCLES = 16, stub never asserts aes_ready -> RECOVER after 16 cycles, timeout_err = 1, done = 0, state IDLE.
